// File: rtl/mul_pkg.sv
// Shared constants for the multiply datapaths: controller state encoding and
// the default operand widths also used by the array multiplier bench.
package mul_pkg;

    localparam int MUL_N = 4;
    localparam int MUL_M = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mul_row.sv
// One multiply row: z = ({N{d}} & x) + u + b, built as an and-gate row
// feeding a ripple chain of full adders with b as the carry-in.
module mul_row #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] u,
    input  logic         d,
    input  logic         b,
    output logic [N:0]   z
);

    logic [N:0]   carry_s;
    logic [N-1:0] pp_s;

    // ripple full-adder chain over the gated partial product
    always_comb begin
        carry_s    = {(N+1){1'b0}};
        pp_s       = {N{1'b0}};
        z          = {(N+1){1'b0}};
        carry_s[0] = b;
        for (int i = 0; i < N; i++) begin
            pp_s[i]      = x[i] & d;
            z[i]         = pp_s[i] ^ u[i] ^ carry_s[i];
            carry_s[i+1] = (pp_s[i] & u[i]) | (pp_s[i] & carry_s[i]) | (u[i] & carry_s[i]);
        end
        z[N] = carry_s[N];
    end

endmodule

// File: rtl/seq_mul_ctrl.sv
// Iterative multiply-add p = x*y + u + v, one mul_row reused for M cycles.
// Optional build macro SEQ_MUL_EARLY_EXIT_EN stops once remaining y/v bits are zero.
module seq_mul_ctrl
    import mul_pkg::*;
#(
    parameter int N = MUL_N,
    parameter int M = MUL_M
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   u,
    input  logic [M-1:0]   y,
    input  logic [M-1:0]   v,
    output logic           busy,
    output logic           done,
    output logic [N+M-1:0] p
);

    localparam int KW = (M > 1) ? $clog2(M) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(M - 1);

    logic [1:0]     state_r;
    logic [N-1:0]   x_r;
    logic [M-1:0]   y_r;
    logic [M-1:0]   v_r;
    logic [N-1:0]   acc_hi_r;
    logic [M-1:0]   lo_r;
    logic [KW-1:0]  k_r;
    logic           busy_r;
    logic           done_r;
    logic [N+M-1:0] p_r;

    logic [N:0]     row_s;
    logic [M-1:0]   lo_nxt_s;
    logic           last_s;
    logic [N+M-1:0] p_nxt_s;

    mul_row #(.N(N)) u_row (
        .x (x_r),
        .u (acc_hi_r),
        .d (y_r[k_r]),
        .b (v_r[k_r]),
        .z (row_s)
    );

    // low product bit of this row lands at position k
    always_comb begin
        lo_nxt_s       = lo_r;
        lo_nxt_s[k_r]  = row_s[0];
    end

`ifdef SEQ_MUL_EARLY_EXIT_EN
    logic [KW:0]    sh_s;
    logic [M-1:0]   rem_s;
    logic [N+M-1:0] hi_ext_s;

    // finish as soon as no weight remains above row k; upper lo bits are still zero
    always_comb begin
        sh_s     = {1'b0, k_r} + {{KW{1'b0}}, 1'b1};
        rem_s    = (y_r | v_r) >> sh_s;
        last_s   = (rem_s == {M{1'b0}});
        hi_ext_s = {{M{1'b0}}, row_s[N:1]};
        p_nxt_s  = (hi_ext_s << sh_s) | {{N{1'b0}}, lo_nxt_s};
    end
`else
    // fixed M rows
    always_comb begin
        last_s  = (k_r == LAST_K);
        p_nxt_s = {row_s[N:1], lo_nxt_s};
    end
`endif

    // controller and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            x_r      <= {N{1'b0}};
            y_r      <= {M{1'b0}};
            v_r      <= {M{1'b0}};
            acc_hi_r <= {N{1'b0}};
            lo_r     <= {M{1'b0}};
            k_r      <= {KW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            p_r      <= {(N+M){1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x_r      <= x;
                        y_r      <= y;
                        v_r      <= v;
                        acc_hi_r <= u;
                        lo_r     <= {M{1'b0}};
                        k_r      <= {KW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_hi_r <= row_s[N:1];
                    lo_r     <= lo_nxt_s;
                    k_r      <= k_r + KW'(1'b1);
                    if (last_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        p_r     <= p_nxt_s;
                        state_r <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign p    = p_r;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Self-checking bench for seq_mul_ctrl: cycle-level reference model of the
// start/busy/done contract plus directed, random and exhaustive operand sweeps.
module tb_seq_mul_ctrl;

    localparam int N = 4;
    localparam int M = 3;
`ifdef SEQ_MUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic           clk;
    logic           reset;
    logic           start;
    logic [N-1:0]   x;
    logic [N-1:0]   u;
    logic [M-1:0]   y;
    logic [M-1:0]   v;
    logic           busy;
    logic           done;
    logic [N+M-1:0] p;

    seq_mul_ctrl #(.N(N), .M(M)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x     (x),
        .u     (u),
        .y     (y),
        .v     (v),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: visible outputs and remaining busy cycles
    bit exp_busy = 1'b0;
    bit exp_done = 1'b0;
    int exp_p    = 0;
    int cnt      = 0;
    int res      = 0;

    function automatic int lat(input int yi, input int vi);
        int m;
        m = 0;
        if (EE) begin
            for (int i = 0; i < M; i++)
                if ((((yi | vi) >> i) & 1) != 0) m = i + 1;
            return (m == 0) ? 1 : m;
        end else begin
            return M;
        end
    endfunction

    task automatic model_edge(output bit acc);
        acc = 1'b0;
        if (!reset) begin
            exp_busy = 1'b0; exp_done = 1'b0; exp_p = 0; cnt = 0;
        end else if (exp_busy) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                exp_busy = 1'b0; exp_done = 1'b1; exp_p = res;
            end
        end else if (start) begin
            acc = 1'b1;
            exp_busy = 1'b1; exp_done = 1'b0;
            cnt = lat(int'(y), int'(v));
            res = int'(x) * int'(y) + int'(u) + int'(v);
        end else begin
            exp_busy = 1'b0; exp_done = 1'b0;
        end
    endtask

    task automatic check(input string tag);
        n_checks++;
        if (busy !== exp_busy) begin
            n_fail++;
            $display("FAIL %s busy: got %0b expected %0b at %0t", tag, busy, exp_busy, $time);
        end
        n_checks++;
        if (done !== exp_done) begin
            n_fail++;
            $display("FAIL %s done: got %0b expected %0b at %0t", tag, done, exp_done, $time);
        end
        n_checks++;
        if (int'(p) !== exp_p) begin
            n_fail++;
            $display("FAIL %s p: got %0d expected %0d at %0t", tag, p, exp_p, $time);
        end
    endtask

    task automatic tick(input bit s, input int xi, input int yi, input int ui, input int vi,
                        input string tag, output bit acc);
        start = s;
        x = N'(xi); y = M'(yi); u = N'(ui); v = M'(vi);
        model_edge(acc);
        @(negedge clk);
        check(tag);
    endtask

    task automatic lit(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // one operation with literal expectations; optional start poke mid-run
    task automatic run_op(input int xi, input int yi, input int ui, input int vi, input int poke,
                          input int want_p, input int want_cyc, input string tag);
        bit acc;
        int cyc;
        int nbusy;
        int ndone;
        tick(1'b1, xi, yi, ui, vi, tag, acc);
        cyc = 1; nbusy = busy ? 1 : 0; ndone = 0;
        while (!done && cyc < 20) begin
            if (cyc == poke) tick(1'b1, 1, 1, 1, 1, tag, acc);
            else             tick(1'b0, xi, yi, ui, vi, tag, acc);
            cyc++;
            if (busy) nbusy++;
        end
        if (done) ndone = 1;
        lit({tag, "_done_seen"}, ndone, 1);
        lit({tag, "_p"}, int'(p), want_p);
        lit({tag, "_cycles"}, cyc, want_cyc);
        lit({tag, "_busy_cycles"}, nbusy, want_cyc - 1);
    endtask

    initial begin
        bit acc;
        int guard;
        reset = 1'b0; start = 1'b0; x = '0; y = '0; u = '0; v = '0;
        repeat (3) @(negedge clk);
        check("reset");
        lit("reset_p_literal", int'(p), 0);
        reset = 1'b1;
        tick(1'b0, 0, 0, 0, 0, "idle", acc);

        run_op(5, 3, 0, 0, 0, 15, EE ? 3 : 4, "op_5x3");
        run_op(3, 2, 0, 0, 0, 6, EE ? 3 : 4, "b2b_3x2");
        tick(1'b0, 0, 0, 0, 0, "gap", acc);
        tick(1'b0, 0, 0, 0, 0, "gap", acc);
        lit("p_held_idle", int'(p), 6);
        run_op(9, 5, 2, 1, 2, 48, 4, "poke_9x5");
        tick(1'b0, 0, 0, 0, 0, "gap", acc);
        run_op(15, 7, 15, 7, 0, 127, 4, "max");
        tick(1'b0, 0, 0, 0, 0, "gap", acc);
        run_op(1, 1, 0, 0, 0, 1, EE ? 2 : 4, "y1");
        tick(1'b0, 0, 0, 0, 0, "gap", acc);
        run_op(7, 0, 9, 0, 0, 9, EE ? 2 : 4, "y0_u9");

        // asynchronous reset during the second RUN cycle
        tick(1'b1, 9, 5, 2, 1, "rst_run", acc);
        tick(1'b0, 9, 5, 2, 1, "rst_run", acc);
        reset = 1'b0;
        model_edge(acc);
        #1;
        check("async_reset");
        lit("async_reset_p", int'(p), 0);
        tick(1'b0, 0, 0, 0, 0, "rst_low", acc);
        reset = 1'b1;
        for (int i = 0; i < M + 3; i++) tick(1'b0, 0, 0, 0, 0, "post_reset", acc);

        // random traffic
        for (int i = 0; i < 3000; i++)
            tick(($urandom % 3) == 0, $urandom % 16, $urandom % 8, $urandom % 16, $urandom % 8,
                 "random", acc);
        for (int i = 0; i < M + 2; i++) tick(1'b0, 0, 0, 0, 0, "drain", acc);

        // exhaustive sweep with start held, so every result is back-to-back
        for (int xi = 0; xi < 16; xi++)
            for (int yi = 0; yi < 8; yi++)
                for (int ui = 0; ui < 16; ui++)
                    for (int vi = 0; vi < 8; vi++) begin
                        acc = 1'b0; guard = 0;
                        while (!acc && guard < 10) begin
                            tick(1'b1, xi, yi, ui, vi, "sweep", acc);
                            guard++;
                        end
                        if (!acc) lit("sweep_accept", 0, 1);
                    end
        for (int i = 0; i < M + 2; i++) tick(1'b0, 0, 0, 0, 0, "sweep_drain", acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mul_ctrl.md
Name: seq_mul_ctrl

Overview:
- Iterative N x M multiply-add unit. Computes p = x*y + u + v with v[k] weighted 2^k, the same function as the combinational array multiplier.
- Reuses one N-bit multiply row for M cycles instead of instantiating M rows.
- Controller sequences operand capture, row iteration, partial-sum shifting and result delivery behind a start/busy/done handshake.
- Sits beside the array multiplier as the area-reduced option for lab datapaths.

Parameters:
- N, 4, multiplicand / addend u width
- M, 3, multiplier / carry-vector v width (M >= 1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled on rising clk; operands captured on the same edge
- x  in  N  multiplicand
- u  in  N  addend
- y  in  M  multiplier
- v  in  M  weighted carry vector
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid
- p  out  N+M  product register, held until next done

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, done=0, p=0, all internal registers 0. Reset mid-operation aborts it; no done is issued for that operation.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, capture x, y, v; acc_hi<=u; lo<=0; k<=0; go to RUN; busy=1 from the next cycle.
- RUN, each cycle:
  - row = ({N{y[k]}} & x) + acc_hi + v[k], N+1 bits.
  - lo[k] <= row[0]; acc_hi <= row[N:1]; k <= k+1.
  - After row M-1, go to DONE.
- DONE: for one cycle, p = {acc_hi, lo}, done=1, busy=0.
  - start=1 in DONE is accepted: a back-to-back operation enters RUN directly.
  - Otherwise return to IDLE.
- Latency: done high exactly M+1 cycles after the start-sampling edge; throughput is one result per M+1 cycles.
- start while busy=1 (RUN) is ignored; captured operands are stable after capture.
- Width: no overflow is possible. The maximum result (2^N-1)(2^M-1)+(2^N-1)+(2^M-1) = 2^(N+M)-1 fits in N+M bits.
- p changes only on the done cycle; it holds its last value across IDLE and RUN.

Optional Feature:
- Macro: SEQ_MUL_EARLY_EXIT_EN.
- Defined: RUN ends after row k when the remaining bits y[M-1:k+1] and v[M-1:k+1] are all zero. Then p = (acc_hi << (k+1)) | lo.
  - Latency becomes L+1 cycles, with L = max(1, msb_index(y|v)+1).
  - Example: y=0, v=0 gives done 2 cycles after start, with p=u.
- Not defined: fixed M+1 latency; the remaining-bits detector is not synthesized.

Decomposition:
- Package mul_pkg: state encoding localparams (IDLE, RUN, DONE) and default N/M constants shared with the array multiplier bench.
- One sub-module, mul_row: combinational N-bit and-gate plus ripple full-adder row, computing (N+1)-bit z from x, u, d and b.
- The controller instantiates a single mul_row and owns all registers.

Test Plan:
- Reset then x=5, y=3, u=0, v=0, start pulse -> done at cycle M+1=4, p=15, busy high for 3 cycles.
- x=9, y=5, u=2, v=1 -> p=48. Max case x=15, y=7, u=15, v=7 -> p=127, no overflow.
- Back-to-back: start held on the DONE cycle with x=3, y=2 -> second done 4 cycles later, p=6; first p=15 visible on first done.
- start pulsed mid-RUN with different operands -> ignored, original result delivered, no extra done.
- reset driven low during RUN cycle 2 -> busy=0, done=0, p=0 immediately; no done after release.
- Exhaustive sweep of all x, y, u, v vs. x*y+u+v model. With SEQ_MUL_EARLY_EXIT_EN: y=1, v=0 -> done 2 cycles after start; y=0, v=0, u=9 -> p=9.
